// File: rtl/addsub_arbiter2_pkg.sv
// Shared encodings for the two-requester add/sub arbiter: FSM states and requester ids.
package addsub_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter2_addsub32.sv
// 32-bit ripple-carry adder/subtractor with carry out and signed overflow (C31 ^ C32).
module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] ans,
  output logic        cout,
  output logic        v
);

  logic [32:0] c;
  logic [31:0] bx;

  // Subtraction is A + ~B + 1: invert B and feed sub in as the carry-in.
  always_comb begin
    bx   = b ^ {32{sub}};
    c    = '0;
    ans  = '0;
    c[0] = sub;
    for (int i = 0; i < 32; i++) begin
      ans[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[32];
  assign v    = c[31] ^ c[32];

endmodule

// File: rtl/addsub_arbiter2.sv
// Round-robin arbiter feeding one shared addsub32; one operation in flight, result
// returned with requester id on a valid/ready response port plus a saturating overflow count.
module addsub_arbiter2
  import addsub_arbiter2_pkg::*;
#(
  parameter int RR_START = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_ans,
  output logic             rsp_cout,
  output logic             rsp_v,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             busy
);

  state_t      state, state_nxt;
  logic        rr_ptr;
  logic        any_vld;
  logic        gnt_id;
  logic        accept;
  logic [31:0] a_p0, b_p0;
  logic        sub_p0, id_p0;
  logic [31:0] ans;
  logic        cout, v;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  always_comb begin
    any_vld    = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? rr_ptr : (req1_valid ? REQ1 : REQ0);
    accept     = (state == IDLE) & any_vld & ~rst;
    req0_ready = accept & (gnt_id == REQ0);
    req1_ready = accept & (gnt_id == REQ1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'(RR_START);
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_ans   <= '0;
      rsp_cout  <= 1'b0;
      rsp_v     <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (accept) rr_ptr <= ~gnt_id;
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_p0;
        rsp_ans   <= ans;
        rsp_cout  <= cout;
        rsp_v     <= v;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      // Clear has priority over an overflow landing in the same cycle.
      if (ovf_clr) ovf_cnt <= '0;
      else if (state == EXEC && v) ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

  // Stage p0: operand capture on the grant cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= (gnt_id == REQ1) ? req1_a : req0_a;
      b_p0   <= (gnt_id == REQ1) ? req1_b : req0_b;
      sub_p0 <= (gnt_id == REQ1) ? req1_sub : req0_sub;
      id_p0  <= gnt_id;
    end
  end

  addsub32 u_addsub (
    .a    (a_p0),
    .b    (b_p0),
    .sub  (sub_p0),
    .ans  (ans),
    .cout (cout),
    .v    (v)
  );

endmodule

// File: tb/tb_addsub_arbiter2.sv
// Randomized and directed bench for addsub_arbiter2 against a transaction-level timing model.
module tb_addsub_arbiter2;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_sub;
  logic [31:0]      req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_sub;
  logic [31:0]      req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_v;
  logic [31:0]      rsp_ans;
  logic             ovf_clr;
  logic [CNT_W-1:0] ovf_cnt;
  logic             busy;

  always #5 clk = ~clk;

  addsub_arbiter2 #(.RR_START(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ans(rsp_ans),
    .rsp_cout(rsp_cout), .rsp_v(rsp_v), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model: one op in flight, accepted at cycle m_acc, visible from m_acc+2 until handshake.
  bit          m_known = 0;
  bit          m_busy = 0;
  int          m_acc = 0;
  int          cyc = 0;
  bit          m_rr = 0;
  int          m_cnt = 0;
  logic [31:0] e_ans = '0, p_ans = '0;
  bit          e_cout = 0, e_v = 0, e_id = 0;
  bit          p_cout = 0, p_v = 0, p_id = 0;

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                 output logic [31:0] ans, output bit cout, output bit v);
    logic [32:0] s;
    if (sub) s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else     s = {1'b0, a} + {1'b0, b};
    ans  = s[31:0];
    cout = s[32];
    if (sub) v = (a[31] != b[31]) && (ans[31] != a[31]);
    else     v = (a[31] == b[31]) && (ans[31] != a[31]);
  endfunction

  task automatic cycle();
    bit exp_rv, g, gid;
    @(negedge clk);
    exp_rv = m_busy && (cyc >= m_acc + 2);
    gid    = (req0_valid && req1_valid) ? m_rr : req1_valid;
    g      = !rst && !m_busy && (req0_valid || req1_valid);
    check("req0_ready", req0_ready, g && gid == 1'b0);
    check("req1_ready", req1_ready, g && gid == 1'b1);
    if (m_known) begin
      check("rsp_valid", rsp_valid, exp_rv);
      check("busy", busy, m_busy);
      check("ovf_cnt", ovf_cnt, m_cnt);
      check("rsp_id", rsp_id, e_id);
      check("rsp_ans", rsp_ans, e_ans);
      check("rsp_cout", rsp_cout, e_cout);
      check("rsp_v", rsp_v, e_v);
    end
    if (rst) begin
      m_known = 1; m_busy = 0; m_rr = 0; m_cnt = 0;
      e_ans = '0; e_cout = 0; e_v = 0; e_id = 0;
    end else begin
      if (m_busy && cyc == m_acc + 1) begin
        e_ans = p_ans; e_cout = p_cout; e_v = p_v; e_id = p_id;
        if (p_v && m_cnt < CNT_MAX) m_cnt++;
      end
      if (ovf_clr) m_cnt = 0;
      if (exp_rv && rsp_ready) m_busy = 0;
      else if (g) begin
        m_busy = 1; m_acc = cyc; m_rr = !gid; p_id = gid;
        if (gid) ref_op(req1_a, req1_b, req1_sub, p_ans, p_cout, p_v);
        else     ref_op(req0_a, req0_b, req0_sub, p_ans, p_cout, p_v);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit vld, input logic [31:0] a, input logic [31:0] b, input bit sub);
    if (id) begin req1_valid = vld; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = vld; req0_a = a; req0_b = b; req0_sub = sub; end
  endtask

  // Accept one op then spend the EXEC cycle; returns just after the result becomes visible.
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input bit sub);
    set_req(id, 1, a, b, sub);
    cycle();
    set_req(id, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0001;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] held;
  bit          ids[$];

  initial begin
    rst = 1; rsp_ready = 1; ovf_clr = 0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_ovf_cnt", ovf_cnt, 0);
    check("reset_rsp_ans", rsp_ans, 0);

    run_op(0, 32'h21, 32'h22, 0);
    check("add_valid", rsp_valid, 1);
    check("add_ans", rsp_ans, 32'h43);
    check("add_cout", rsp_cout, 0);
    check("add_v", rsp_v, 0);
    check("add_id", rsp_id, 0);
    cycle();

    run_op(1, 32'h7FFF_FFFF, 32'h1, 0);
    check("ovf_ans", rsp_ans, 32'h8000_0000);
    check("ovf_v", rsp_v, 1);
    check("ovf_id", rsp_id, 1);
    check("ovf_cnt1", ovf_cnt, 1);
    cycle();
    run_op(0, 32'h8000_0000, 32'h1, 1);
    check("subovf_ans", rsp_ans, 32'h7FFF_FFFF);
    check("subovf_cout", rsp_cout, 1);
    check("subovf_v", rsp_v, 1);
    check("ovf_cnt2", ovf_cnt, 2);
    cycle();
    ovf_clr = 1; cycle(); ovf_clr = 0;
    check("ovf_clr", ovf_cnt, 0);

    do_reset();
    set_req(0, 1, 32'h336F_B7E5, 32'h336F_B7E5, 1);
    set_req(1, 1, 32'hBBBB_BBBB, 32'h4444_4444, 0);
    for (int i = 0; i < 30 && ids.size() < 4; i++) begin
      cycle();
      if (rsp_valid) begin
        ids.push_back(rsp_id);
        check("rr_ans", rsp_ans, rsp_id ? 32'hFFFF_FFFF : 32'h0);
        check("rr_cout", rsp_cout, rsp_id ? 0 : 1);
        check("rr_v", rsp_v, 0);
      end
    end
    check("rr_count", ids.size(), 4);
    for (int i = 0; i < ids.size(); i++) check("rr_order", ids[i], i % 2);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    rsp_ready = 0;
    run_op(1, 32'h1234_5678, 32'h1111_1111, 1);
    held = rsp_ans;
    check("bp_ans", held, 32'h0123_4567);
    set_req(0, 1, 32'h5, 32'h6, 0);
    set_req(1, 1, 32'h7, 32'h8, 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_valid", rsp_valid, 1);
      check("bp_hold", rsp_ans, held);
      check("bp_busy", busy, 1);
      check("bp_ready", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1;
    cycle();
    check("bp_idle", busy, 0);
    check("bp_grant", req0_ready | req1_ready, 1);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();

    ovf_clr = 1; cycle(); ovf_clr = 0;
    for (int k = 1; k <= 4; k++) begin
      run_op(0, 32'h7FFF_FFFF, 32'h1, 0);
      check("sat_cnt", ovf_cnt, (k > 3) ? 3 : k);
      cycle();
    end
    set_req(0, 1, 32'h7FFF_FFFF, 32'h1, 0);
    cycle();
    set_req(0, 0, 0, 0, 0);
    ovf_clr = 1; cycle(); ovf_clr = 0;
    check("sat_clr_wins", ovf_cnt, 0);
    cycle();

    set_req(1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    cycle();
    set_req(1, 0, 0, 0, 0);
    rst = 1; cycle(); rst = 0;
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", ovf_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rst_no_rsp", rsp_valid, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      set_req(0, $urandom_range(0, 2) != 0, pick(), pick(), $urandom_range(0, 1) == 1);
      set_req(1, $urandom_range(0, 2) != 0, pick(), pick(), $urandom_range(0, 1) == 1);
      rsp_ready = $urandom_range(0, 3) != 0;
      ovf_clr   = $urandom_range(0, 40) == 0;
      rst       = $urandom_range(0, 150) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter2.md
Name: addsub_arbiter2

Overview:
Two-requester arbiter and sequencer that shares one addsub32 datapath (32-bit ripple add/sub with cout and signed-overflow V).
- Accepts operations on two valid/ready request ports and grants them round-robin.
- Drives the shared addsub32 from registered operands.
- Returns each result with its requester id on a single valid/ready response port.
- Keeps a saturating count of signed overflows for status and debug.

Parameters:
RR_START, 0, requester that has priority after reset (0 or 1).
CNT_W, 8, width of the overflow counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  operand A, requester 0
req0_b  in  32  operand B, requester 0
req0_sub  in  1  1 = A-B, 0 = A+B, requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above, requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_id  out  1  requester that issued the operation
rsp_ans  out  32  addsub32 ans
rsp_cout  out  1  addsub32 carry out
rsp_v  out  1  addsub32 signed overflow
ovf_clr  in  1  synchronous clear of ovf_cnt
ovf_cnt  out  CNT_W  saturating count of responses with V=1
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high. All outputs are registered except req0_ready and req1_ready, which decode state and grant.
- Reset values: FSM=IDLE, rr_ptr=RR_START, rsp_valid=0, rsp_id=0, rsp_ans=0, rsp_cout=0, rsp_v=0, ovf_cnt=0, busy=0, readies=0.
- FSM states and transitions:
  - IDLE -> EXEC when any reqN_valid=1.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready=1.
- IDLE grant rule:
  - Only one valid: grant it, regardless of rr_ptr.
  - Both valid: grant rr_ptr.
  - The granted port sees reqN_ready=1 for exactly this cycle. That cycle's a, b, sub and id are captured into operand registers.
  - rr_ptr becomes the non-granted id.
- EXEC: addsub32 inputs come from the operand registers only. At the end of EXEC, ans/cout/V/id are latched into the rsp_* registers.
- RESP: rsp_valid=1. All rsp_* outputs are held stable until the cycle with rsp_ready=1; FSM then returns to IDLE.
- No acceptance in RESP: reqN_ready=0 in EXEC and RESP. A new operation is accepted at the earliest in the cycle after the response handshake.
- Latency and throughput:
  - Accept at cycle N gives rsp_valid at N+2.
  - Minimum 3 cycles per operation with rsp_ready tied high.
- ovf_cnt:
  - +1 on the EXEC->RESP edge when V=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - ovf_clr=1 forces 0 and wins over a simultaneous increment.
- Arithmetic: modulo 2^32 exactly as addsub32 produces it. Subtract cout=1 means no borrow. V=C31^C32.
- Requester protocol is not checked: a valid deasserted without ready is simply ignored.
- rst in any state: the in-flight operation is discarded with no response, and all registers return to reset values on the next edge.
- rsp_ready high while rsp_valid=0 has no effect.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and the requester id constants REQ0=1'b0, REQ1=1'b1.
- Sub-module: one instance of the existing addsub32, driven from the operand registers.
- Arbiter and FSM logic stay in this module; no further split.

Test Plan:
- Single op, add: after reset, req0 with a=0x00000021, b=0x00000022, sub=0, rsp_ready=1 -> req0_ready pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_ans=0x00000043, cout=0, v=0, id=0.
- Overflow and counter: req1 with a=0x7FFFFFFF, b=0x00000001, sub=0 -> ans=0x80000000, cout=0, v=1, id=1, ovf_cnt=1. Then req0 with a=0x80000000, b=0x00000001, sub=1 -> ans=0x7FFFFFFF, cout=1, v=1, ovf_cnt=2. Then ovf_clr -> ovf_cnt=0.
- Contention (RR_START=0): both valid continuously.
  - req0 holds a=0x336FB7E5, b=0x336FB7E5, sub=1.
  - req1 holds a=0xBBBBBBBB, b=0x44444444, sub=0.
  - Expected response order: id 0,1,0,1.
  - id 0 responses: ans=0, cout=1, v=0.
  - id 1 responses: ans=0xFFFFFFFF, cout=0, v=0.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, both readies 0, busy=1. On rsp_ready=1, FSM returns to IDLE and the next grant occurs the following cycle.
- Saturation: CNT_W=2, four overflowing ops (0x7FFFFFFF+1) -> ovf_cnt reads 1,2,3,3. Assert ovf_clr in the same cycle as a fifth overflow latch -> ovf_cnt=0.
- Reset mid-operation: assert rst during EXEC -> next cycle rsp_valid=0, busy=0, ovf_cnt=0, and no response ever appears for the discarded op.
